// File: rtl/keypad_encoder_p_pkg.sv
// Shared types and helpers for the keypad front end: debounce FSM states and
// the priority encoder that turns a synchronised key vector into a code.
package keypad_pkg;

   localparam int KEY_MAX  = 64;
   localparam int CODE_MAX = 6;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } kp_state_e;

   typedef struct packed {
      logic [CODE_MAX-1:0] code;
      logic                any;
      logic                many;
   } prio_t;

   // Highest set index wins; also reports whether any / more than one key is set.
   function automatic prio_t prio_enc(input logic [KEY_MAX-1:0] vec);
      prio_t       res;
      int unsigned ones;
      res  = '0;
      ones = 0;
      for (int i = 0; i < KEY_MAX; i++) begin
         if (vec[i]) begin
            res.code = CODE_MAX'(i);
            ones     = ones + 1;
         end else begin
            ones     = ones;
         end
      end
      res.any  = (ones != 0);
      res.many = (ones > 1);
      return res;
   endfunction

endpackage

// File: rtl/keypad_encoder_p_if.sv
// Key inputs, mode select and encoded outputs of the keypad front end.
interface keypad_encoder_p_if #(
   parameter int NUM_KEYS = 10,
   parameter int CODE_W   = 4
);
   logic [NUM_KEYS-1:0] key;
   logic                enablen;
   logic [CODE_W-1:0]   D;
   logic                loadn;
   logic                key_valid;
   logic                pgt_1Hz;
   logic                multi_key;

   modport master (output key, enablen,
                   input  D, loadn, key_valid, pgt_1Hz, multi_key);
   modport slave  (input  key, enablen,
                   output D, loadn, key_valid, pgt_1Hz, multi_key);
endinterface

// File: rtl/keypad_encoder_p_tick_divider.sv
// Free-running modulo-DIV_RATIO counter; tick marks the last count before wrap.
module tick_divider #(
   parameter int DIV_RATIO = 100
) (
   input  logic clk,
   input  logic clrn,
   output logic tick
);
   localparam int DIV_W = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;

   logic [DIV_W-1:0] count_r;

   assign tick = (count_r == DIV_W'(DIV_RATIO - 1));

   // Count register, wraps to zero after the terminal count.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         count_r <= '0;
      end else if (tick) begin
         count_r <= '0;
      end else begin
         count_r <= count_r + DIV_W'(1);
      end
   end
endmodule

// File: rtl/keypad_encoder_p.sv
// Keypad front end: synchronise, priority-encode and debounce raw keys, emit one
// code/strobe per press and mux the event pulse with a divided timebase.
module keypad_encoder_p
   import keypad_pkg::*;
#(
   parameter int NUM_KEYS        = 10,
   parameter int CODE_W          = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DIV_RATIO       = 100,
   parameter int SYNC_STAGES     = 2
) (
   input logic              clk,
   input logic              clrn,
   keypad_encoder_p_if.slave bus
);
   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam bit              INSTANT = (DEBOUNCE_CYCLES == 1);

   logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] sync_r;
   logic [NUM_KEYS-1:0]  ks_s;
   prio_t                enc_s;
   kp_state_e            state_r, state_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s, cnt_inc_s;
   logic [CODE_MAX-1:0]  cand_r, cand_s, acc_code_s;
   logic                 accept_s;
   logic [CODE_W-1:0]    d_r;
   logic                 key_valid_r, loadn_r, multi_r, pgt_r;
   logic                 tick_s, pgt_src_s;

   tick_divider #(.DIV_RATIO(DIV_RATIO)) u_div (
      .clk  (clk),
      .clrn (clrn),
      .tick (tick_s)
   );

   assign ks_s      = sync_r[SYNC_STAGES-1];
   assign enc_s     = prio_enc(KEY_MAX'(ks_s));
   assign pgt_src_s = bus.enablen ? tick_s : key_valid_r;

   // Synchroniser chain for the asynchronous key lines.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], bus.key};
      end
   end

   // Debounce next-state logic; acceptance is the single-cycle strobe request.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      cand_s     = cand_r;
      accept_s   = 1'b0;
      acc_code_s = cand_r;
      cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
      if (bus.enablen) begin
         state_s = IDLE;
         cnt_s   = '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (enc_s.any) begin
                  cand_s = enc_s.code;
                  cnt_s  = CNT_ONE;
                  if (INSTANT) begin
                     accept_s   = 1'b1;
                     acc_code_s = enc_s.code;
                     state_s    = HELD;
                  end else begin
                     state_s    = PRESS_DB;
                  end
               end else begin
                  cnt_s = '0;
               end
            end
            PRESS_DB: begin
               if (!enc_s.any) begin
                  state_s = IDLE;
                  cnt_s   = '0;
               end else if (enc_s.code != cand_r) begin
                  cand_s = enc_s.code;
                  cnt_s  = CNT_ONE;
               end else begin
                  cnt_s = cnt_inc_s;
                  if (cnt_inc_s >= CNT_MAX) begin
                     accept_s = 1'b1;
                     state_s  = HELD;
                  end else begin
                     state_s  = PRESS_DB;
                  end
               end
            end
            HELD: begin
               if (!enc_s.any) begin
                  cnt_s   = INSTANT ? '0 : CNT_ONE;
                  state_s = INSTANT ? IDLE : REL_DB;
               end else begin
                  state_s = HELD;
               end
            end
            REL_DB: begin
               if (enc_s.any) begin
                  state_s = HELD;
               end else if (cnt_inc_s >= CNT_MAX) begin
                  state_s = IDLE;
                  cnt_s   = '0;
               end else begin
                  cnt_s   = cnt_inc_s;
               end
            end
            default: begin
               state_s = IDLE;
               cnt_s   = '0;
            end
         endcase
      end
   end

   // FSM state, candidate code and registered outputs.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         cand_r      <= '0;
         d_r         <= '0;
         key_valid_r <= 1'b0;
         loadn_r     <= 1'b1;
         multi_r     <= 1'b0;
         pgt_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         cand_r      <= cand_s;
         d_r         <= accept_s ? acc_code_s[CODE_W-1:0] : d_r;
         key_valid_r <= accept_s;
         loadn_r     <= ~accept_s;
         multi_r     <= accept_s & enc_s.many;
         // Masking with the previous value keeps the pulse one cycle wide across mode flips.
         pgt_r       <= pgt_src_s & ~pgt_r;
      end
   end

   assign bus.D         = d_r;
   assign bus.loadn     = loadn_r;
   assign bus.key_valid = key_valid_r;
   assign bus.multi_key = multi_r;
   assign bus.pgt_1Hz   = pgt_r;
endmodule

// File: tb/tb_keypad_encoder_p.sv
// Self-checking bench for keypad_encoder_p: directed scenarios plus random key
// traffic, compared every cycle against a run-length reference model.
module tb_keypad_encoder_p;
   localparam int NK  = 10;
   localparam int CW  = 4;
   localparam int N   = 4;
   localparam int DIV = 100;
   localparam int S   = 2;

   logic clk  = 1'b0;
   logic clrn = 1'b0;

   keypad_encoder_p_if #(.NUM_KEYS(NK), .CODE_W(CW)) bus ();

   keypad_encoder_p #(
      .NUM_KEYS(NK), .CODE_W(CW), .DEBOUNCE_CYCLES(N),
      .DIV_RATIO(DIV), .SYNC_STAGES(S)
   ) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: keys reach the debouncer S edges late; a press is a run of
   // N equal non-empty codes while armed, re-arming needs a run of N empty samples.
   logic [NK-1:0] ks_q[$];
   bit            armed;
   int            press_run, rel_run, prev_code;
   logic [CW-1:0] m_d;
   bit            m_kv, m_multi, m_pgt;
   int            edge_k;
   int            strobes, pulses, multi_seen, strobe_at;

   function automatic int top_index(input logic [NK-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NK; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_k);
      end
   endtask

   task automatic model_reset();
      ks_q = {};
      for (int i = 0; i < S; i++) ks_q.push_back('0);
      armed     = 1'b1;
      press_run = 0;
      rel_run   = 0;
      prev_code = -1;
      m_d       = '0;
      m_kv      = 1'b0;
      m_multi   = 1'b0;
      m_pgt     = 1'b0;
      edge_k    = 0;
   endtask

   task automatic model_edge();
      logic [NK-1:0] ks;
      bit tick, nk, new_pgt;
      tick = ((edge_k % DIV) == DIV - 1);
      ks   = ks_q.pop_front();
      ks_q.push_back(bus.key);
      nk      = 1'b0;
      new_pgt = (bus.enablen ? tick : m_kv) && !m_pgt;
      if (bus.enablen) begin
         armed     = 1'b1;
         press_run = 0;
      end else if (armed) begin
         if (ks != '0) begin
            if (press_run > 0 && top_index(ks) == prev_code) press_run++;
            else press_run = 1;
            prev_code = top_index(ks);
            if (press_run >= N) begin
               nk      = 1'b1;
               m_d     = CW'(prev_code);
               m_multi = ($countones(ks) > 1);
               armed   = 1'b0;
               rel_run = 0;
            end
         end else begin
            press_run = 0;
         end
      end else begin
         if (ks == '0) begin
            rel_run++;
            if (rel_run >= N) begin
               armed     = 1'b1;
               press_run = 0;
            end
         end else begin
            rel_run = 0;
         end
      end
      if (!nk) m_multi = 1'b0;
      m_kv  = nk;
      m_pgt = new_pgt;
      edge_k++;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("D",         32'(bus.D),         32'(m_d));
      check("loadn",     32'(bus.loadn),     32'(!m_kv));
      check("key_valid", 32'(bus.key_valid), 32'(m_kv));
      check("pgt_1Hz",   32'(bus.pgt_1Hz),   32'(m_pgt));
      check("multi_key", 32'(bus.multi_key), 32'(m_multi));
      if (bus.key_valid === 1'b1) begin
         strobes++;
         strobe_at = edge_k - 1;
      end
      if (bus.pgt_1Hz === 1'b1) pulses++;
      if (bus.multi_key === 1'b1) multi_seen++;
   endtask

   task automatic apply_reset(input int n);
      clrn = 1'b0;
      model_reset();
      repeat (n) @(posedge clk);
      @(negedge clk);
      check("rst_D",         32'(bus.D),         32'd0);
      check("rst_loadn",     32'(bus.loadn),     32'd1);
      check("rst_key_valid", 32'(bus.key_valid), 32'd0);
      check("rst_pgt_1Hz",   32'(bus.pgt_1Hz),   32'd0);
      check("rst_multi_key", 32'(bus.multi_key), 32'd0);
      clrn = 1'b1;
   endtask

   initial begin
      int e0, r, hold;
      bus.key     = '0;
      bus.enablen = 1'b1;
      strobes = 0; pulses = 0; multi_seen = 0; strobe_at = -1;

      // Reset and idle timebase in countdown mode.
      apply_reset(3);
      repeat (250) cycle();
      check("idle_pgt_pulses", 32'(pulses), 32'd2);
      check("idle_no_strobe", 32'(strobes), 32'd0);

      // Clean press of key 5.
      bus.enablen = 1'b0;
      repeat (10) cycle();
      strobes = 0;
      e0 = edge_k;
      bus.key = 10'b0000100000;
      repeat (20) cycle();
      check("clean_strobes", 32'(strobes), 32'd1);
      check("clean_latency", 32'(strobe_at - e0), 32'd5);
      check("clean_D", 32'(bus.D), 32'd5);
      bus.key = '0;
      repeat (10) cycle();
      check("clean_release", 32'(strobes), 32'd1);

      // Bouncing key 3, then a short release glitch while held.
      strobes = 0;
      for (int i = 0; i < 5; i++) begin
         bus.key = (i % 2 == 1) ? 10'b0000001000 : 10'b0000000000;
         repeat (2) cycle();
      end
      check("bounce_quiet", 32'(strobes), 32'd0);
      e0 = edge_k;
      bus.key = 10'b0000001000;
      repeat (12) cycle();
      check("bounce_strobes", 32'(strobes), 32'd1);
      check("bounce_latency", 32'(strobe_at - e0), 32'd5);
      check("bounce_D", 32'(bus.D), 32'd3);
      bus.key = '0;
      repeat (2) cycle();
      bus.key = 10'b0000001000;
      repeat (8) cycle();
      check("glitch_strobes", 32'(strobes), 32'd1);
      bus.key = '0;
      repeat (10) cycle();

      // Keys 2 and 7 together.
      strobes = 0; multi_seen = 0;
      bus.key = 10'b0010000100;
      repeat (10) cycle();
      check("multi_strobes", 32'(strobes), 32'd1);
      check("multi_D", 32'(bus.D), 32'd7);
      check("multi_width", 32'(multi_seen), 32'd1);
      bus.key = '0;
      repeat (10) cycle();

      // Mode switch during a key 1 press.
      strobes = 0; pulses = 0;
      bus.key = 10'b0000000010;
      repeat (4) cycle();
      bus.enablen = 1'b1;
      repeat (150) cycle();
      check("mode_no_strobe", 32'(strobes), 32'd0);
      check("mode_D_held", 32'(bus.D), 32'd7);
      check("mode_pgt_resumed", 32'(pulses > 0), 32'd1);
      bus.key = '0;
      bus.enablen = 1'b0;
      repeat (10) cycle();

      // Reset in the middle of a key 9 press.
      bus.key = 10'b1000000000;
      repeat (4) cycle();
      apply_reset(2);
      strobes = 0;
      repeat (10) cycle();
      check("rstpress_strobes", 32'(strobes), 32'd1);
      check("rstpress_latency", 32'(strobe_at), 32'd5);
      check("rstpress_D", 32'(bus.D), 32'd9);
      bus.key = '0;
      repeat (10) cycle();

      // Random key traffic with occasional mode flips.
      for (int seg = 0; seg < 200; seg++) begin
         bus.enablen = ($urandom_range(0, 9) == 0);
         r = $urandom_range(0, 9);
         if (r < 3) bus.key = '0;
         else if (r < 8) bus.key = NK'(1) << $urandom_range(0, NK - 1);
         else bus.key = NK'($urandom);
         hold = $urandom_range(1, 10);
         repeat (hold) cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/keypad_encoder_p.md
Name: keypad_encoder_p

Overview:
- Parametrised next-generation keypad front end for the microwave controller.
- Accepts NUM_KEYS raw active-high keys and synchronises them into clk.
- Debounces presses and releases with a counter-based FSM. Emits one code plus strobe per physical press (no auto-repeat).
- Muxes its event pulse with an internal divided timebase onto pgt_1Hz. The downstream timer/counter chain clocks from pgt_1Hz in both keypad-entry and countdown modes.

Parameters:
- NUM_KEYS, 10, number of key inputs; key[i] encodes to value i.
- CODE_W, 4, width of D; must satisfy 2**CODE_W >= NUM_KEYS.
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press or a release; >= 1.
- DIV_RATIO, 100, clk cycles per timebase tick; >= 2.
- SYNC_STAGES, 2, synchroniser flops on key; >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- key  in  NUM_KEYS  raw keypad lines, active high, asynchronous to clk.
- enablen  in  1  0 = keypad entry mode, 1 = countdown mode (keys ignored, timebase drives pgt_1Hz).
- D  out  CODE_W  encoded code of the last accepted key; holds until the next acceptance.
- loadn  out  1  active-low one-cycle load strobe on press acceptance.
- key_valid  out  1  active-high one-cycle strobe, coincident with loadn low.
- pgt_1Hz  out  1  event pulse to downstream counters.
- multi_key  out  1  high with the strobe if more than one key was active at acceptance; otherwise low.

Behaviour:
- Reset values: clrn low asynchronously forces all state to reset, at any point including mid-debounce.
  - D=0, loadn=1, key_valid=0, pgt_1Hz=0, multi_key=0.
  - FSM=IDLE, debounce counter=0, divider counter=0, synchroniser flops=0.
- Synchroniser: key passes through SYNC_STAGES flops, producing ks.
- Priority encode: ks feeds a priority encoder; the highest set index wins.
  - Produces code, any (OR of ks) and many (popcount > 1).
- FSM states:
  - IDLE: when any=1, latch code into cand and set cnt=1; go to PRESS_DB.
  - PRESS_DB:
    - any=0 goes to IDLE.
    - Code differs from cand: reload cand, set cnt=1, stay.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, accept:
      - D<=cand, key_valid=1, loadn=0, multi_key<=many for exactly one cycle.
      - Go to HELD.
  - HELD: wait for any=0, then set cnt=1 and go to REL_DB. Code changes while held produce no event.
  - REL_DB:
    - any=1 goes back to HELD with no new strobe (bounce rejection).
    - Otherwise cnt++; at DEBOUNCE_CYCLES go to IDLE.
- Latency (DEBOUNCE_CYCLES=N, SYNC_STAGES=S): key held stable from before edge 0 produces the strobe in the cycle after edge S+N-1. For N=4, S=2 this is one cycle high after edge 5.
- Mode:
  - enablen=1 forces the FSM to IDLE synchronously and suppresses strobes. D holds its value.
  - A strobe in the same cycle enablen rises is suppressed.
- Divider:
  - Free-running 0..DIV_RATIO-1, independent of mode.
  - tick=1 when count==DIV_RATIO-1, then wraps to 0.
- pgt_1Hz (registered, one cycle late relative to its source):
  - enablen=0: follows key_valid.
  - enablen=1: follows tick.
  - Never wider than one cycle.
- Widths: cnt is clog2(DEBOUNCE_CYCLES+1) bits and saturates, never wrapping. Divider is clog2(DIV_RATIO) bits.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state enum (IDLE, PRESS_DB, HELD, REL_DB).
  - Function prio_enc(NUM_KEYS-wide vector) returning code, any and many.
- Natural sub-module tick_divider (parameter DIV_RATIO; ports clk, clrn, tick). It replaces the old fixed divide-by-100.

Test Plan:
- Reset/idle: clrn low 3 cycles, no keys -> all outputs at reset values; with enablen=1, pgt_1Hz pulses exactly every 100 cycles, one cycle wide.
- Clean press: enablen=0, key=10'b0000100000 held 20 cycles -> exactly one key_valid/loadn pulse after edge 5, D=5, multi_key=0, pgt_1Hz one cycle later; nothing further on release.
- Bounce: key[3] toggles every 2 cycles for 10 cycles, then holds -> no strobe during toggling; a single strobe with D=3 four synchronised cycles after it settles. A 2-cycle release glitch while HELD -> no second strobe.
- Multi-key: key[2] and key[7] pressed together -> D=7, multi_key=1 on the strobe cycle only.
- Mode switch: press key[1], raise enablen at edge 4 -> no strobe, D unchanged; pgt_1Hz resumes divider ticks.
- Reset mid-press: assert clrn at edge 4 of a key[9] press, release clrn with key still held -> full debounce restarts; strobe at edge 5 after release, D=9.
